// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port: CPU port front-end for TMS9918/V99x8 VDPs: control latch, auto-increment VRAM pointer and ordered VRAM command queue.
// Optional VDP_PORT_WAIT_EN: stall the CPU through wait_n instead of dropping commands on a full queue.
module vdp_cpu_port #(
    parameter int VRAM_AW = 14,
    parameter int QDEPTH  = 4,
    parameter int HI_REG  = 14,
    parameter int REG_AW  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic               rd,
    input  logic               wr,
    input  logic               req,
    input  logic               mode,
    input  logic [7:0]         cd_i,
    output logic [7:0]         cd_o,
    input  logic [7:0]         status_i,
    output logic               status_rd,
    output logic               reg_we,
    output logic [REG_AW-1:0]  reg_addr,
    output logic [7:0]         reg_data,
    output logic               vram_req,
    input  logic               vram_ack,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata,
    output logic               busy,
`ifdef VDP_PORT_WAIT_EN
    output logic               wait_n,
`endif
    output logic               overflow
);
    localparam int QAW = $clog2(QDEPTH);
    localparam int CW  = QAW + 1;
    localparam int EW  = VRAM_AW + 9;
    localparam logic [VRAM_AW-1:0] LO = VRAM_AW'(14'h3FFF);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t              state_q, state_d;
    logic                tog_q, tog_d;
    logic [7:0]          latch_q, latch_d;
    logic [VRAM_AW-1:0]  ptr_q, ptr_d, ptr_set;
    logic [7:0]          rbuf_q, rbuf_d;
    logic                rd_prev_q, status_rd_q;
    logic                reg_we_q, reg_we_d;
    logic [REG_AW-1:0]   reg_addr_q, reg_addr_d;
    logic [7:0]          reg_data_q, reg_data_d;
    logic                ovf_q, ovf_d;
    logic [EW-1:0]       q_mem [QDEPTH];
    logic [QAW-1:0]      head_q, tail_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [EW-1:0]       head;
    logic                head_we;
    logic                wr_ev, rd_ev, pop, full;
    logic                push, push_we;
    logic [VRAM_AW-1:0]  push_addr;
    logic [7:0]          push_data;
    logic                c_val, c_we, c_ok, do_push;
    logic [VRAM_AW-1:0]  c_addr;
    logic [7:0]          c_data;

    assign wr_ev   = cs && wr && req;
    assign rd_ev   = cs && rd && !rd_prev_q;
    assign head    = q_mem[head_q];
    assign head_we = head[EW-1];
    assign pop     = (state_q == ISSUE) && vram_ack;
    assign full    = cnt_q == CW'(QDEPTH);

    // Port decode; a write event wins over a read edge in the same cycle.
    always_comb begin
        tog_d      = tog_q;
        latch_d    = latch_q;
        ptr_d      = ptr_q;
        ptr_set    = (ptr_q & ~LO) | VRAM_AW'({cd_i[5:0], latch_q});
        rbuf_d     = (pop && !head_we) ? vram_rdata : rbuf_q;
        reg_we_d   = 1'b0;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        push       = 1'b0;
        push_we    = 1'b0;
        push_addr  = ptr_q;
        push_data  = cd_i;
        if (wr_ev && mode && !tog_q) begin
            latch_d = cd_i;
            tog_d   = 1'b1;
        end else if (wr_ev && mode) begin
            tog_d = 1'b0;
            if (cd_i[7]) begin
                reg_we_d   = 1'b1;
                reg_addr_d = cd_i[REG_AW-1:0];
                reg_data_d = latch_q;
                if (VRAM_AW > 14 && cd_i[REG_AW-1:0] == REG_AW'(HI_REG))
                    ptr_d = (ptr_q & LO) | (VRAM_AW'(latch_q) << 14);
            end else begin
                push      = !cd_i[6];
                push_addr = ptr_set;
                ptr_d     = cd_i[6] ? ptr_set : ptr_set + VRAM_AW'(1);
            end
        end else if (wr_ev) begin
            push    = 1'b1;
            push_we = 1'b1;
            rbuf_d  = cd_i;
            ptr_d   = ptr_q + VRAM_AW'(1);
            tog_d   = 1'b0;
        end else if (rd_ev) begin
            tog_d = 1'b0;
            push  = !mode;
            ptr_d = mode ? ptr_q : ptr_q + VRAM_AW'(1);
        end
    end

`ifdef VDP_PORT_WAIT_EN
    // A command that cannot enter the queue is parked here while the CPU is stalled.
    logic               pend_q, pend_we_q, pend_dr_q, c_dr;
    logic [VRAM_AW-1:0] pend_addr_q;
    logic [7:0]         pend_data_q;
    logic [CW-1:0]      rdq_q;

    assign c_val  = pend_q | push;
    assign c_we   = pend_q ? pend_we_q : push_we;
    assign c_addr = pend_q ? pend_addr_q : push_addr;
    assign c_data = pend_q ? pend_data_q : push_data;
    assign c_dr   = pend_q ? pend_dr_q : (rd_ev && !wr_ev && !mode);
    assign c_ok   = (!full || pop) && !(c_dr && rdq_q != '0);
    assign ovf_d  = ovf_q;
    assign wait_n = !pend_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
            rdq_q  <= '0;
        end else begin
            pend_q <= c_val && !c_ok;
            rdq_q  <= rdq_q + CW'(do_push && !c_we) - CW'(pop && !head_we);
        end
    end

    always_ff @(posedge clk) begin
        if (!pend_q) begin
            pend_we_q   <= push_we;
            pend_addr_q <= push_addr;
            pend_data_q <= push_data;
            pend_dr_q   <= c_dr;
        end
    end
`else
    assign c_val  = push;
    assign c_we   = push_we;
    assign c_addr = push_addr;
    assign c_data = push_data;
    assign c_ok   = !full || pop;
    assign ovf_d  = ovf_q | (c_val && !c_ok);
`endif

    assign do_push = c_val && c_ok;
    assign cnt_d   = cnt_q + CW'(do_push) - CW'(pop);

    always_comb begin
        state_d = (state_q == IDLE) ? ((cnt_q != '0) ? ISSUE : IDLE)
                                    : (pop ? ((cnt_d != '0) ? ISSUE : IDLE) : ISSUE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tog_q       <= 1'b0;
            latch_q     <= '0;
            ptr_q       <= '0;
            rbuf_q      <= '0;
            rd_prev_q   <= 1'b0;
            status_rd_q <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            ovf_q       <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tog_q       <= tog_d;
            latch_q     <= latch_d;
            ptr_q       <= ptr_d;
            rbuf_q      <= rbuf_d;
            rd_prev_q   <= cs && rd;
            status_rd_q <= rd_ev && mode && !wr_ev;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            ovf_q       <= ovf_d;
            head_q      <= head_q + QAW'(pop);
            tail_q      <= tail_q + QAW'(do_push);
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) q_mem[tail_q] <= {c_we, c_addr, c_data};
    end

    assign cd_o       = (cs && rd) ? (mode ? status_i : rbuf_q) : 8'hFF;
    assign status_rd  = status_rd_q;
    assign reg_we     = reg_we_q;
    assign reg_addr   = reg_addr_q;
    assign reg_data   = reg_data_q;
    assign vram_req   = state_q == ISSUE;
    assign vram_we    = vram_req && head_we;
    assign vram_addr  = vram_req ? head[EW-2:8] : '0;
    assign vram_wdata = vram_we ? head[7:0] : '0;
    assign busy       = vram_req || cnt_q != '0;
    assign overflow   = ovf_q;
endmodule
